pc_redirect: RTL and testbench

Control-flow redirect unit that drives the write port of the program counter. It accepts resolved branch, jump, call and return requests from the execute stage over a valid/ready handshake, and computes the 9-bit byte target. It keeps a small return-address stack and pulses the PC write-enable with the new address. It also asserts a flush to squash wrong-path instructions already fetched by the sequential PC+4 path.

---
 rtl/pc_redirect_if.sv | 25 ++
 rtl/pc_redirect.sv | 146 ++++++++++++++
 tb/tb_pc_redirect.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_if.sv
// Request channel from the execute stage into the PC redirect unit.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; the master holds its fields stable while req_valid
// is high and req_ready is low, and req_ready never depends on req_valid.
interface pc_redirect_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic              req_cond;
    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W-1:0] req_offset;
    logic [ADDR_W-1:0] req_target;

    modport master (
        output req_valid, req_type, req_cond, req_base, req_offset, req_target,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_type, req_cond, req_base, req_offset, req_target,
        output req_ready
    );
endinterface

// File: rtl/pc_redirect.sv
// Control-flow redirect unit: turns resolved branch/jump/call/return requests
// into a one-cycle PC write plus a multi-cycle flush, with a circular
// return-address stack that overwrites its oldest entry when full.
module pc_redirect #(
    parameter int ADDR_W       = 9,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    pc_redirect_if.slave      req,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_new_addr,
    output logic              flush,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              misalign_err,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [ADDR_W-1:0] target_q;
    logic              misalign_q;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_wp_q;
    logic [PTR_W:0]    ras_cnt_q;
    logic [PTR_W-1:0]  ras_top;

    logic              accept;
    logic              redirect;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] raw_target;

    // The write pointer points at the next free slot; the top entry sits just below it.
    assign ras_top   = ras_wp_q - PTR_W'(1);
    assign ras_empty = (ras_cnt_q == '0);
    assign ras_full  = (ras_cnt_q == (PTR_W+1)'(RAS_DEPTH));

    assign req.req_ready = (state_q == IDLE) && reset;
    assign accept        = req.req_valid && req.req_ready;

    // Decode the request into a raw target and the stack operation it implies.
    always_comb begin
        raw_target = req.req_target;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        redirect   = 1'b0;
        case (req.req_type)
            2'b00: begin
                raw_target = req.req_base + ADDR_W'(4) + req.req_offset;
                redirect   = accept && req.req_cond;
            end
            2'b01: begin
                redirect = accept;
            end
            2'b10: begin
                do_push  = accept;
                redirect = accept;
            end
            default: begin
                if (!ras_empty) begin
                    raw_target = ras_mem[ras_top];
                    do_pop     = accept;
                end
                redirect = accept;
            end
        endcase
    end

    // State register and flush-length counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == REDIRECT) begin
                flush_cnt_q <= CNT_W'(FLUSH_CYCLES - 1);
            end else if (state_q == FLUSH) begin
                flush_cnt_q <= flush_cnt_q - CNT_W'(1);
            end
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        flush     = 1'b0;
        dbg_state = state_q;
        case (state_q)
            IDLE: begin
                if (redirect) state_d = REDIRECT;
            end
            REDIRECT: begin
                pc_we   = 1'b1;
                flush   = 1'b1;
                state_d = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
            end
            FLUSH: begin
                flush = 1'b1;
                if (flush_cnt_q == CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the aligned target; the misalign flag lives only for the REDIRECT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            target_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (redirect) begin
                target_q   <= {raw_target[ADDR_W-1:2], 2'b00};
                misalign_q <= |raw_target[1:0];
            end
        end
    end

    assign pc_new_addr  = target_q;
    assign misalign_err = misalign_q;

    // Return-address stack: circular, so a push when full overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ras_wp_q  <= '0;
            ras_cnt_q <= '0;
        end else if (do_push) begin
            ras_mem[ras_wp_q] <= req.req_base + ADDR_W'(4);
            ras_wp_q          <= ras_wp_q + PTR_W'(1);
            if (!ras_full) ras_cnt_q <= ras_cnt_q + (PTR_W+1)'(1);
        end else if (do_pop) begin
            ras_wp_q  <= ras_top;
            ras_cnt_q <= ras_cnt_q - (PTR_W+1)'(1);
        end
    end
endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect: reset, taken/not-taken branches, call/return,
// RAS overflow, wrap-around with misalignment and reset during a redirect.
module tb_pc_redirect;
    logic       clk;
    logic       reset;
    logic       pc_we;
    logic [8:0] pc_new_addr;
    logic       flush;
    logic       ras_empty;
    logic       ras_full;
    logic       misalign_err;
    logic [1:0] dbg_state;

    int passed;
    int total;

    pc_redirect_if #(.ADDR_W(9)) rif ();

    pc_redirect #(.ADDR_W(9), .RAS_DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (rif.slave),
        .pc_we        (pc_we),
        .pc_new_addr  (pc_new_addr),
        .flush        (flush),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .misalign_err (misalign_err),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one request for one edge, then drop valid; returns at N+1 (+1ns).
    task automatic send(input logic [1:0] t, input logic c, input logic [8:0] base,
                        input logic [8:0] off, input logic [8:0] tgt);
        rif.req_valid  = 1'b1;
        rif.req_type   = t;
        rif.req_cond   = c;
        rif.req_base   = base;
        rif.req_offset = off;
        rif.req_target = tgt;
        @(posedge clk); #1;
        rif.req_valid  = 1'b0;
    endtask

    // Driver: step through the rest of a redirect (FLUSH cycle, then back to IDLE).
    task automatic settle();
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rif.req_valid = 1'b0;
        rif.req_type = 2'b00; rif.req_cond = 1'b0;
        rif.req_base = '0; rif.req_offset = '0; rif.req_target = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        total++; if (pc_we !== 1'b0) $display("FAIL reset_pc_we: got %b expected 0", pc_we); else passed++;
        total++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b expected 0", flush); else passed++;
        total++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b expected 0", misalign_err); else passed++;
        total++; if (pc_new_addr !== 9'h000) $display("FAIL reset_addr: got %h expected 000", pc_new_addr); else passed++;
        total++; if (ras_empty !== 1'b1) $display("FAIL reset_ras_empty: got %b expected 1", ras_empty); else passed++;
        total++; if (ras_full !== 1'b0) $display("FAIL reset_ras_full: got %b expected 0", ras_full); else passed++;
        total++; if (rif.req_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", rif.req_ready); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (rif.req_ready !== 1'b1) $display("FAIL reset_ready_release: got %b expected 1", rif.req_ready); else passed++;
    endtask

    task automatic test_taken_branch();
        send(2'b00, 1'b1, 9'h010, 9'h008, 9'h000);
        total++; if (pc_we !== 1'b1) $display("FAIL br_pc_we: got %b expected 1", pc_we); else passed++;
        total++; if (pc_new_addr !== 9'h01C) $display("FAIL br_addr: got %h expected 01c", pc_new_addr); else passed++;
        total++; if (flush !== 1'b1) $display("FAIL br_flush1: got %b expected 1", flush); else passed++;
        total++; if (rif.req_ready !== 1'b0) $display("FAIL br_ready1: got %b expected 0", rif.req_ready); else passed++;
        total++; if (misalign_err !== 1'b0) $display("FAIL br_misalign: got %b expected 0", misalign_err); else passed++;
        @(posedge clk); #1;
        total++; if (pc_we !== 1'b0) $display("FAIL br_pc_we2: got %b expected 0", pc_we); else passed++;
        total++; if (flush !== 1'b1) $display("FAIL br_flush2: got %b expected 1", flush); else passed++;
        total++; if (rif.req_ready !== 1'b0) $display("FAIL br_ready2: got %b expected 0", rif.req_ready); else passed++;
        @(posedge clk); #1;
        total++; if (flush !== 1'b0) $display("FAIL br_flush3: got %b expected 0", flush); else passed++;
        total++; if (rif.req_ready !== 1'b1) $display("FAIL br_ready3: got %b expected 1", rif.req_ready); else passed++;
        total++; if (pc_new_addr !== 9'h01C) $display("FAIL br_addr_hold: got %h expected 01c", pc_new_addr); else passed++;
    endtask

    task automatic test_not_taken();
        rif.req_valid = 1'b1;
        rif.req_type = 2'b00; rif.req_cond = 1'b0;
        rif.req_base = 9'h030; rif.req_offset = 9'h040; rif.req_target = 9'h000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (pc_we !== 1'b0) $display("FAIL nt_pc_we[%0d]: got %b expected 0", i, pc_we); else passed++;
            total++; if (flush !== 1'b0) $display("FAIL nt_flush[%0d]: got %b expected 0", i, flush); else passed++;
            total++; if (rif.req_ready !== 1'b1) $display("FAIL nt_ready[%0d]: got %b expected 1", i, rif.req_ready); else passed++;
        end
        rif.req_valid = 1'b0;
        total++; if (pc_new_addr !== 9'h01C) $display("FAIL nt_addr_hold: got %h expected 01c", pc_new_addr); else passed++;
    endtask

    task automatic test_call_return();
        send(2'b10, 1'b0, 9'h020, 9'h000, 9'h100);
        total++; if (pc_new_addr !== 9'h100) $display("FAIL call_addr: got %h expected 100", pc_new_addr); else passed++;
        total++; if (ras_empty !== 1'b0) $display("FAIL call_ras_empty: got %b expected 0", ras_empty); else passed++;
        settle();
        send(2'b11, 1'b0, 9'h100, 9'h000, 9'h000);
        total++; if (pc_we !== 1'b1) $display("FAIL ret_pc_we: got %b expected 1", pc_we); else passed++;
        total++; if (pc_new_addr !== 9'h024) $display("FAIL ret_addr: got %h expected 024", pc_new_addr); else passed++;
        total++; if (ras_empty !== 1'b1) $display("FAIL ret_ras_empty: got %b expected 1", ras_empty); else passed++;
        settle();
    endtask

    task automatic test_ras_overflow();
        logic [8:0] bases [5];
        logic [8:0] exp_ret [5];
        bases   = '{9'h000, 9'h004, 9'h008, 9'h00C, 9'h010};
        exp_ret = '{9'h014, 9'h010, 9'h00C, 9'h008, 9'h0C0};
        for (int i = 0; i < 5; i++) begin
            send(2'b10, 1'b0, bases[i], 9'h000, 9'h080);
            total++; if (pc_new_addr !== 9'h080) $display("FAIL ovf_call_addr[%0d]: got %h expected 080", i, pc_new_addr); else passed++;
            total++; if (ras_full !== (i >= 3)) $display("FAIL ovf_full[%0d]: got %b expected %b", i, ras_full, (i >= 3)); else passed++;
            settle();
        end
        for (int i = 0; i < 5; i++) begin
            send(2'b11, 1'b0, 9'h080, 9'h000, 9'h0C0);
            total++; if (pc_new_addr !== exp_ret[i]) $display("FAIL ovf_ret_addr[%0d]: got %h expected %h", i, pc_new_addr, exp_ret[i]); else passed++;
            total++; if (ras_empty !== (i >= 3)) $display("FAIL ovf_empty[%0d]: got %b expected %b", i, ras_empty, (i >= 3)); else passed++;
            settle();
        end
    endtask

    task automatic test_wrap_misalign();
        send(2'b00, 1'b1, 9'h1FC, 9'h002, 9'h000);
        total++; if (pc_new_addr !== 9'h000) $display("FAIL wrap_addr: got %h expected 000", pc_new_addr); else passed++;
        total++; if (misalign_err !== 1'b1) $display("FAIL wrap_misalign1: got %b expected 1", misalign_err); else passed++;
        @(posedge clk); #1;
        total++; if (misalign_err !== 1'b0) $display("FAIL wrap_misalign2: got %b expected 0", misalign_err); else passed++;
        @(posedge clk); #1;
        send(2'b01, 1'b0, 9'h000, 9'h000, 9'h123);
        total++; if (pc_new_addr !== 9'h120) $display("FAIL jump_addr: got %h expected 120", pc_new_addr); else passed++;
        total++; if (misalign_err !== 1'b1) $display("FAIL jump_misalign: got %b expected 1", misalign_err); else passed++;
        settle();
    endtask

    task automatic test_reset_mid_redirect();
        send(2'b10, 1'b0, 9'h040, 9'h000, 9'h100);
        total++; if (pc_we !== 1'b1) $display("FAIL mid_pc_we_pre: got %b expected 1", pc_we); else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (pc_we !== 1'b0) $display("FAIL mid_pc_we: got %b expected 0", pc_we); else passed++;
        total++; if (flush !== 1'b0) $display("FAIL mid_flush: got %b expected 0", flush); else passed++;
        total++; if (ras_empty !== 1'b1) $display("FAIL mid_ras_empty: got %b expected 1", ras_empty); else passed++;
        total++; if (pc_new_addr !== 9'h000) $display("FAIL mid_addr: got %h expected 000", pc_new_addr); else passed++;
        total++; if (rif.req_ready !== 1'b0) $display("FAIL mid_ready_low: got %b expected 0", rif.req_ready); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (rif.req_ready !== 1'b1) $display("FAIL mid_ready_release: got %b expected 1", rif.req_ready); else passed++;
        total++; if (pc_we !== 1'b0) $display("FAIL mid_pc_we_after: got %b expected 0", pc_we); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_taken_branch();
        test_not_taken();
        test_call_return();
        test_ras_overflow();
        test_wrap_misalign();
        test_reset_mid_redirect();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
